// File: rtl/tick_gen_multi_if.sv
// Configuration bus for tick_gen_multi: period/mode load strobe with target channel.
// The master drives a single-cycle write; the slave (tick generator) samples it on clk.
interface tick_gen_multi_if #(
   parameter int unsigned N_CH  = 3,
   parameter int unsigned CNT_W = 26
);
   localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             cfg_we;
   logic [ChW-1:0]   cfg_ch;
   logic [CNT_W-1:0] cfg_period;
   logic             cfg_oneshot;

   modport master (
      output cfg_we,
      output cfg_ch,
      output cfg_period,
      output cfg_oneshot
   );

   modport slave (
      input cfg_we,
      input cfg_ch,
      input cfg_period,
      input cfg_oneshot
   );
endinterface

// File: rtl/tick_gen_multi.sv
// N-channel tick generator: each channel strobes tick[i] for one clk every max(period,1) clocks.
// Define TICK_GEN_ONESHOT_EN to add per-channel one-shot mode with armed flags.
module tick_gen_multi #(
   parameter int unsigned            N_CH        = 3,
   parameter int unsigned            CNT_W       = 26,
   parameter logic [N_CH*CNT_W-1:0]  DEF_PERIODS = {26'd50_000_000, 26'd2_500_000, 26'd50_000}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_CH-1:0]      ch_en,
   input  logic                 sync_clr,
   tick_gen_multi_if.slave      cfg,
   output logic [N_CH-1:0]      tick,
   output logic [N_CH-1:0]      armed
);

   localparam int unsigned ChW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [N_CH-1:0][CNT_W-1:0] period_q, period_d;
   logic [N_CH-1:0][CNT_W-1:0] last_cnt;
   logic [N_CH-1:0]            tick_q, tick_d;
   logic [N_CH-1:0]            cfg_hit;
   logic [N_CH-1:0]            term;
   logic [N_CH-1:0]            run;

   // Channel decode and terminal-count detection; period 0 behaves like 1.
   always_comb begin
      cfg_hit  = '0;
      last_cnt = '0;
      term     = '0;
      for (int i = 0; i < N_CH; i++) begin
         cfg_hit[i]  = cfg.cfg_we && (cfg.cfg_ch == ChW'(i));
         last_cnt[i] = (period_q[i] == '0) ? '0 : period_q[i] - CNT_W'(1);
         term[i]     = cnt_q[i] >= last_cnt[i];
      end
   end

`ifdef TICK_GEN_ONESHOT_EN
   logic [N_CH-1:0] mode_q, mode_d;
   logic [N_CH-1:0] armed_q, armed_d;

   // A one-shot channel only counts while armed; a periodic one whenever enabled.
   always_comb begin
      run = '0;
      for (int i = 0; i < N_CH; i++) begin
         run[i] = ch_en[i] && (!mode_q[i] || armed_q[i]);
      end
   end

   always_comb begin
      mode_d  = mode_q;
      armed_d = armed_q;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_hit[i]) begin
            mode_d[i]  = cfg.cfg_oneshot;
            armed_d[i] = cfg.cfg_oneshot;
         end else if (!sync_clr && run[i] && term[i] && mode_q[i]) begin
            armed_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= '0;
         armed_q <= '0;
      end else begin
         mode_q  <= mode_d;
         armed_q <= armed_d;
      end
   end

   assign armed = armed_q;
`else
   logic unused_cfg_oneshot;

   assign unused_cfg_oneshot = cfg.cfg_oneshot;
   assign run                = ch_en;
   assign armed              = '0;
`endif

   // Clear sources share one priority slot for the counter; the period write is independent.
   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      tick_d   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_hit[i]) begin
            period_d[i] = cfg.cfg_period;
         end
         if (sync_clr || cfg_hit[i] || !run[i]) begin
            cnt_d[i] = '0;
         end else if (term[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         period_q <= DEF_PERIODS;
         tick_q   <= '0;
      end else begin
         cnt_q    <= cnt_d;
         period_q <= period_d;
         tick_q   <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_chk
      a_cnt_bound : assert property (@(posedge clk) disable iff (rst) cnt_q[g] <= last_cnt[g]);
   end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Randomized bench for tick_gen_multi against a next-tick arithmetic model (phase start + k*P).
// Honours TICK_GEN_ONESHOT_EN the same way as the design.
module tb_tick_gen_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] ch_en;
   logic       sync_clr;
   logic [2:0] tick;
   logic [2:0] armed;

   tick_gen_multi_if #(.N_CH(3), .CNT_W(26)) cfg_bus ();

   tick_gen_multi #(
      .N_CH        (3),
      .CNT_W       (26),
      .DEF_PERIODS ({26'd10, 26'd5, 26'd3})
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_en    (ch_en),
      .sync_clr (sync_clr),
      .cfg      (cfg_bus),
      .tick     (tick),
      .armed    (armed)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Model: a channel ticks at phase_start + k*P_eff while it stays enabled and uncleared.
   int         m_edge;
   int         m_start [3];
   int         m_per   [3];
   bit         m_mode  [3];
   bit         m_armed [3];
   logic [2:0] m_tick;
   logic [2:0] m_armed_v;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (edge %0d)", tag, got, exp, m_edge);
      end
   endtask

   task automatic model_reset();
      m_edge    = 0;
      m_per[0]  = 3;
      m_per[1]  = 5;
      m_per[2]  = 10;
      m_tick    = '0;
      m_armed_v = '0;
      for (int i = 0; i < 3; i++) begin
         m_start[i] = 0;
         m_mode[i]  = 1'b0;
         m_armed[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic [2:0] en, input logic sync, input logic we,
                             input logic [1:0] ch, input logic [25:0] per, input logic os);
      int  peff;
      bit  hit;
      m_edge++;
      for (int i = 0; i < 3; i++) begin
         hit       = we && (int'(ch) == i);
         m_tick[i] = 1'b0;
         if (hit) begin
            m_per[i] = int'(per);
`ifdef TICK_GEN_ONESHOT_EN
            m_mode[i]  = os;
            m_armed[i] = os;
`endif
         end
         peff = (m_per[i] == 0) ? 1 : m_per[i];
         if (sync || hit || !en[i]) begin
            m_start[i] = m_edge;
         end else if (m_mode[i]) begin
            if (!m_armed[i]) begin
               m_start[i] = m_edge;
            end else if (m_edge - m_start[i] == peff) begin
               m_tick[i]  = 1'b1;
               m_armed[i] = 1'b0;
               m_start[i] = m_edge;
            end
         end else if ((m_edge - m_start[i]) % peff == 0) begin
            m_tick[i] = 1'b1;
         end
         m_armed_v[i] = m_armed[i];
      end
   endtask

   // Apply inputs at negedge, clock once, compare #1 after the edge, return at next negedge.
   task automatic step(input logic [2:0] en, input logic sync, input logic we,
                       input logic [1:0] ch, input logic [25:0] per, input logic os,
                       input string tag);
      ch_en               = en;
      sync_clr            = sync;
      cfg_bus.cfg_we      = we;
      cfg_bus.cfg_ch      = ch;
      cfg_bus.cfg_period  = per;
      cfg_bus.cfg_oneshot = os;
      @(posedge clk);
      model_edge(en, sync, we, ch, per, os);
      #1;
      check_eq({tag, "_tick"}, 32'(tick), 32'(m_tick));
      check_eq({tag, "_armed"}, 32'(armed), 32'(m_armed_v));
      @(negedge clk);
   endtask

   task automatic run_en(input int n, input string tag);
      for (int k = 0; k < n; k++) step(3'b111, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, tag);
   endtask

   // Reset is raised between edges so its asynchronous effect is visible before any clock.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq({tag, "_rst_tick"}, 32'(tick), 32'd0);
      check_eq({tag, "_rst_armed"}, 32'(armed), 32'd0);
      ch_en               = '0;
      sync_clr            = 1'b0;
      cfg_bus.cfg_we      = 1'b0;
      cfg_bus.cfg_ch      = '0;
      cfg_bus.cfg_period  = '0;
      cfg_bus.cfg_oneshot = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [2:0]  r_en;
      logic [1:0]  r_ch;
      logic [25:0] r_per;
      rst = 1'b1;
      model_reset();
      do_reset("t0");

      // Default periods 3/5/10.
      for (int e = 1; e <= 20; e++) begin
         step(3'b111, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, "t1");
         if (e == 5)  check_eq("t1_e5",  32'(tick), 32'b010);
         if (e == 9)  check_eq("t1_e9",  32'(tick), 32'b001);
         if (e == 10) check_eq("t1_e10", 32'(tick), 32'b110);
         if (e == 20) check_eq("t1_e20", 32'(tick), 32'b110);
      end

      // Runtime reload of ch1 to period 2 at edge 7.
      do_reset("t2");
      run_en(6, "t2");
      step(3'b111, 1'b0, 1'b1, 2'd1, 26'd2, 1'b0, "t2w");
      step(3'b111, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, "t2");
      check_eq("t2_e8", 32'(tick[1]), 32'd0);
      step(3'b111, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, "t2");
      check_eq("t2_e9", 32'(tick[1]), 32'd1);
      run_en(5, "t2");

      // Disable ch0 for two cycles at cnt=1; restart costs a full period.
      do_reset("t3");
      run_en(1, "t3");
      step(3'b110, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, "t3");
      step(3'b110, 1'b0, 1'b0, 2'd0, 26'd0, 1'b0, "t3");
      run_en(2, "t3");
      check_eq("t3_e5", 32'(tick[0]), 32'd0);
      run_en(1, "t3");
      check_eq("t3_e6", 32'(tick[0]), 32'd1);

      // Global phase clear at edge 4.
      do_reset("t4");
      run_en(3, "t4");
      step(3'b111, 1'b1, 1'b0, 2'd0, 26'd0, 1'b0, "t4s");
      run_en(3, "t4");
      check_eq("t4_e7", 32'(tick), 32'b001);
      run_en(2, "t4");
      check_eq("t4_e9", 32'(tick), 32'b010);
      run_en(6, "t4");

      // Period 0 on ch2, then a write to the nonexistent channel 3.
      do_reset("t5");
      step(3'b111, 1'b0, 1'b1, 2'd2, 26'd0, 1'b0, "t5w");
      run_en(4, "t5");
      check_eq("t5_p0", 32'(tick[2]), 32'd1);
      step(3'b111, 1'b0, 1'b1, 2'd3, 26'd1, 1'b0, "t5x");
      run_en(12, "t5");
      check_eq("t5_p0b", 32'(tick[2]), 32'd1);

`ifdef TICK_GEN_ONESHOT_EN
      do_reset("t6");
      step(3'b111, 1'b0, 1'b1, 2'd0, 26'd4, 1'b1, "t6w");
      check_eq("t6_armed", 32'(armed[0]), 32'd1);
      run_en(55, "t6");
      step(3'b111, 1'b0, 1'b1, 2'd0, 26'd4, 1'b1, "t6w2");
      run_en(2, "t6");
      do_reset("t6m");
`endif

      // Random traffic.
      do_reset("t7");
      r_en = 3'b111;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 7) == 0) r_en = 3'($urandom_range(0, 7));
         r_ch  = 2'($urandom_range(0, 3));
         r_per = 26'($urandom_range(0, 12));
         step(r_en, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) == 0), r_ch, r_per,
              1'($urandom_range(0, 1)), "rnd");
         if (k == 400) do_reset("t7m");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
